rgb_fade_driver: RTL and testbench
==================================

# rgb_fade_driver

Downstream stage of the dynamic LED lights block. Takes the 3-bit `colour` code and drives three physical LED pins (red, green, blue) with PWM. It cross-fades smoothly between colours instead of switching abruptly. The block has one free-running PWM counter and three per-channel duty registers, each ramping toward a target set by the sampled colour bit.

## Interface
- `PWM_BITS`, 8: width of the PWM counter; the period is 2^PWM_BITS cycles.
- `MAX_DUTY`, 255: duty of a fully-on channel. Must be ≤ 2^PWM_BITS−1.
- `STEP`, 17: duty change applied per PWM period while fading. Must be ≥ 1.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `colour`  in  3  colour code; bit 2 = red, bit 1 = green, bit 0 = blue.
- `led_r`, `led_g`, `led_b`  out  1 each  registered PWM outputs.
- `busy`  out  1  high while any channel duty ≠ its target.

## Operation
- `colour_q` (3 bits) registers `colour` every cycle.
- Per-channel target: `colour_q[i] ? MAX_DUTY : 0`.
- All 8 codes are legal. 000 means all off and 111 means all on; no special-casing.
- `cnt` (PWM_BITS) free-runs from 0 to 2^PWM_BITS−1 and wraps to 0.
- Period boundary: the cycle where `cnt` is all ones. Duty registers update only on this cycle.
- Ramp rule per channel at a boundary, computed at PWM_BITS+1 width so there is no overflow:
  - duty < target: duty ← min(duty+STEP, target).
  - duty > target: duty ← max(duty−STEP, target), with no underflow below 0.
  - Otherwise: hold.
- Clamping guarantees no overshoot. Direction reverses immediately if the target changes mid-fade.
- PWM compare: `led_x ← (cnt < duty_x)`, registered.
  - duty 0 gives the pin constantly low.
  - duty D gives D high cycles per period.
- `busy` is combinational from registers: OR over channels of (duty_x ≠ target_x).
- Channels are independent. Each one ramps in its own direction in the same boundary cycle.

## Timing
- Reset (synchronous, `rst`=1 at posedge) clears `cnt`, all duties, `colour_q`, `led_r/g/b` to 0. `busy` is therefore 0.
- Reset mid-fade aborts the fade. Outputs go 0 at the edge where reset is sampled, and the ramp does not resume.
- Colour-to-target latency: 1 cycle, via `colour_q`. `busy` rises 1 cycle after a `colour` change that alters any target.
- The first duty change happens at the next boundary after `colour_q` updates. A change sampled on the boundary cycle itself applies at the following boundary.
- Duty-to-pin latency: 1 cycle. The pin reflects `cnt`/duty from the previous cycle.
- Full fade 0→MAX_DUTY takes ceil(MAX_DUTY/STEP) boundaries. With defaults: 15 periods = 3840 cycles.
- `busy` falls in the cycle after the final clamped update.
- The colour may change every cycle. Only the value in `colour_q` at each boundary cycle matters for the ramp.

## Test plan
- Reset:
  - Stimulus: hold `rst`=1 for 3 cycles with `colour`=3'b101, then release with `colour`=3'b000.
  - Required: all LEDs 0 and `busy`=0 during reset and indefinitely afterwards.
- Fade up:
  - Stimulus: defaults, `colour` 000→100.
  - Required: `busy`=1 one cycle later. `duty_r` = 17, 34, …, 255 on successive boundaries. `busy`=0 after the 15th boundary. Thereafter `led_r` is high 255 of 256 cycles; `led_g`/`led_b` stay 0.
- Reversal:
  - Stimulus: `colour` 000→100, then →000 after 5 boundaries (duty 85).
  - Required: duty goes 68, 51, 34, 17, 0 on the next 5 boundaries, then `busy`=0.
- Clamp:
  - Stimulus: `MAX_DUTY`=250, `STEP`=17, `colour`→010.
  - Required: `duty_g` goes …, 221, 238, 250 and holds at 250; never 255. 250 high cycles per period.
- Mixed directions:
  - Stimulus: reach steady `colour`=110, then switch to 011.
  - Required: red falls 255→0 while blue rises 0→255 over the same 15 boundaries; green constant at 255; `busy`=1 throughout, then 0.
- Reset mid-fade:
  - Stimulus: assert `rst` for 1 cycle at duty 119 during a fade to 111.
  - Required: all LEDs 0 and `cnt`=0 next cycle. After release with `colour` still 111, the fade restarts from 0 (17 at first boundary).

Source files
------------

// File: rtl/rgb_fade_if.sv
// Colour input and PWM LED outputs of the RGB fade driver.
// The master drives the colour code; the slave drives the pins and the busy flag.
interface rgb_fade_if;
    logic [2:0] colour;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       busy;

    modport master (
        output colour,
        input  led_r,
        input  led_g,
        input  led_b,
        input  busy
    );

    modport slave (
        input  colour,
        output led_r,
        output led_g,
        output led_b,
        output busy
    );
endinterface

// File: rtl/rgb_fade_driver.sv
// Three-channel PWM LED driver that cross-fades between colours by ramping each
// channel's duty one STEP per PWM period toward 0 or MAX_DUTY.
module rgb_fade_driver #(
    parameter int PWM_BITS = 8,
    parameter int MAX_DUTY = 255,
    parameter int STEP     = 17
) (
    input  logic        clk,
    input  logic        rst,
    rgb_fade_if.slave   bus
);
    localparam int W = PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
    localparam logic [W-1:0] MAX_W  = W'(MAX_DUTY);
    localparam logic [W-1:0] STEP_W = W'(STEP);

    logic [2:0]          colour_reg;
    logic [PWM_BITS-1:0] cnt_reg;
    logic                boundary;
    logic [2:0]          led_bits;
    logic [2:0]          mismatch;

    assign boundary = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            colour_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            colour_reg <= bus.colour;
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

    // Channel gi follows colour bit gi: 2 = red, 1 = green, 0 = blue.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [W-1:0] target;
            logic [W-1:0] duty_reg;
            logic [W-1:0] duty_next;
            logic [W-1:0] up;
            logic [W-1:0] down;
            logic         led_reg;

            assign target = colour_reg[gi] ? MAX_W : '0;
            assign up     = duty_reg + STEP_W;
            assign down   = duty_reg - STEP_W;

            // Clamp at the target so a ramp never overshoots; the extra bit
            // keeps the upward sum from wrapping.
            always_comb begin
                duty_next = duty_reg;
                if (duty_reg < target) begin
                    duty_next = (up < target) ? up : target;
                end else if (duty_reg > target) begin
                    duty_next = (duty_reg >= STEP_W && down > target) ? down : target;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    duty_reg <= '0;
                    led_reg  <= 1'b0;
                end else begin
                    if (boundary) begin
                        duty_reg <= duty_next;
                    end
                    led_reg <= ({1'b0, cnt_reg} < duty_reg);
                end
            end

            assign led_bits[gi] = led_reg;
            assign mismatch[gi] = (duty_reg != target);
        end
    endgenerate

    assign bus.led_r = led_bits[2];
    assign bus.led_g = led_bits[1];
    assign bus.led_b = led_bits[0];
    assign bus.busy  = |mismatch;
endmodule

// File: tb/tb_rgb_fade_driver.sv
// Scoreboard bench: a default-parameter DUT and a MAX_DUTY=250 DUT share stimulus;
// per-period high counts and per-cycle busy are compared against a ramp model.
module tb_rgb_fade_driver;
    localparam int STEP = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] colour = 3'b101;

    rgb_fade_if if0 ();
    rgb_fade_if if1 ();

    assign if0.colour = colour;
    assign if1.colour = colour;

    rgb_fade_driver #(.PWM_BITS(8), .MAX_DUTY(255), .STEP(STEP)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    rgb_fade_driver #(.PWM_BITS(8), .MAX_DUTY(250), .STEP(STEP)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observed pins, index [dut][2-chan] with chan 0=r,1=g,2=b.
    logic [2:0] led_v [2];
    logic       busy_v [2];
    assign led_v[0]  = {if0.led_r, if0.led_g, if0.led_b};
    assign led_v[1]  = {if1.led_r, if1.led_g, if1.led_b};
    assign busy_v[0] = if0.busy;
    assign busy_v[1] = if1.busy;

    // Reference ramp model and scoreboard of expected per-period duties.
    int          maxd [2] = '{255, 250};
    int          m_cnt = 0;
    logic [2:0]  m_cq = '0;
    int          m_duty [2][3];
    bit          m_rst_q = 1'b1;
    logic [5:0][8:0] sb_q [$];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++)
                m_duty[k][i] = 0;
    end

    always @(posedge clk) begin : model
        logic [5:0][8:0] nxt;
        int t;
        int d;
        m_rst_q <= rst;
        if (rst) begin
            m_cnt <= 0;
            m_cq  <= '0;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 3; i++)
                    m_duty[k][i] <= 0;
            sb_q.delete();
            sb_q.push_back('0);
        end else begin
            if (m_cnt == 255) begin
                nxt = '0;
                for (int k = 0; k < 2; k++) begin
                    for (int i = 0; i < 3; i++) begin
                        t = m_cq[2-i] ? maxd[k] : 0;
                        d = m_duty[k][i];
                        if (d < t)      d = (d + STEP < t) ? d + STEP : t;
                        else if (d > t) d = (d - STEP > t) ? d - STEP : t;
                        nxt[k*3+i] = 9'(d);
                        m_duty[k][i] <= d;
                    end
                end
                sb_q.push_back(nxt);
            end
            m_cq  <= colour;
            m_cnt <= (m_cnt + 1) % 256;
        end
    end

    // Monitor: a window spans the 256 samples that reflect cnt = 0..255.
    bit win_on = 1'b0;
    int hi [2][3];

    always @(negedge clk) begin : monitor
        logic [5:0][8:0] e;
        bit mb;
        for (int k = 0; k < 2; k++) begin
            if (m_rst_q) begin
                check($sformatf("rst_leds%0d", k), 32'(led_v[k]), 32'd0);
                check($sformatf("rst_busy%0d", k), 32'(busy_v[k]), 32'd0);
            end else begin
                mb = 1'b0;
                for (int i = 0; i < 3; i++)
                    if (m_duty[k][i] != (m_cq[2-i] ? maxd[k] : 0)) mb = 1'b1;
                check($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(mb));
            end
        end
        if (m_rst_q) begin
            win_on = 1'b0;
        end else begin
            if (m_cnt == 1) begin
                win_on = 1'b1;
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 3; i++)
                        hi[k][i] = 0;
            end
            if (win_on) begin
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 3; i++)
                        hi[k][i] += int'(led_v[k][2-i]);
            end
            if (win_on && m_cnt == 0) begin
                win_on = 1'b0;
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    for (int k = 0; k < 2; k++) begin
                        $display("[TB] t=%0t dut%0d period highs r=%0d g=%0d b=%0d exp %0d %0d %0d",
                                 $time, k, hi[k][0], hi[k][1], hi[k][2],
                                 e[k*3], e[k*3+1], e[k*3+2]);
                        for (int i = 0; i < 3; i++)
                            check($sformatf("highs_dut%0d_ch%0d", k, i), 32'(hi[k][i]), 32'(e[k*3+i]));
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_colour_for(input logic [2:0] c, input int periods);
        colour = c;
        wait_cyc(periods * 256);
    endtask

    initial begin : stim
        int c;
        // Reset held 3 cycles with a non-zero colour, then release to all-off.
        rst    = 1'b1;
        colour = 3'b101;
        wait_cyc(3);
        rst = 1'b0;
        set_colour_for(3'b000, 3);
        // Fade up red, then back down.
        set_colour_for(3'b100, 17);
        set_colour_for(3'b000, 17);
        // Reversal after 5 boundaries.
        set_colour_for(3'b100, 5);
        set_colour_for(3'b000, 8);
        // Green: clamps at 250 on the second DUT.
        set_colour_for(3'b010, 17);
        // Mixed directions.
        set_colour_for(3'b110, 17);
        set_colour_for(3'b011, 17);
        set_colour_for(3'b000, 17);
        // Fade to white, reset at duty 119, fade restarts from 0.
        colour = 3'b111;
        for (c = 0; c < 4000 && m_duty[0][0] != 119; c++) @(posedge clk);
        if (c >= 4000) check("wait_duty_119_timeout", 32'd0, 32'd1);
        #1;
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(17 * 256);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
